// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALU codes and ALU B-select codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_I_WB     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_BR_NT    = 4'd11,
    ST_ILLEGAL  = 4'd12
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_ZERO = 3'b000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type ALU decoder: maps funct3/funct7[5] to an ALU code; unsupported combinations raise r_illegal_o.
// Purely combinational.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctrl_o,
  output logic       r_illegal_o
);

  always_comb begin
    alu_ctrl_o  = ALU_ADD;
    r_illegal_o = 1'b0;
    case ({funct3_i, funct7_5_i})
      4'b000_0: alu_ctrl_o = ALU_ADD;
      4'b000_1: alu_ctrl_o = ALU_SUB;
      4'b111_0: alu_ctrl_o = ALU_AND;
      4'b110_0: alu_ctrl_o = ALU_OR;
      default:  r_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the RV32I-subset multicycle datapath; cycles: lw 5, sw/R/addi 4, beq 3 taken / 4 not.
// ILLEGAL_SKIP_EN: illegal encodings skip the instruction (PC+4) instead of halting.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       PCSource,
  output logic [3:0] ALUControl,
  output logic       instr_done,
  output logic       illegal
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         r_alu_ctrl;
  logic               r_illegal;
  logic               pc_inc, pcw_m, done_m, br_s;

  alu_decoder u_alu_decoder (
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .alu_ctrl_o (r_alu_ctrl),
    .r_illegal_o(r_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = (funct3 == F3_WORD) ? ST_MEM_ADDR : ST_ILLEGAL;
            OP_RTYPE:     state_d = ST_EXEC_R;
            OP_ADDI:      state_d = (funct3 == F3_ZERO) ? ST_EXEC_I : ST_ILLEGAL;
            OP_BEQ:       state_d = (funct3 == F3_ZERO) ? ST_BRANCH : ST_ILLEGAL;
            default:      state_d = ST_ILLEGAL;
          endcase
        end
        ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD:   state_d = ST_MEM_WB;
        ST_EXEC_R:   state_d = r_illegal ? ST_ILLEGAL : ST_R_WB;
        ST_EXEC_I:   state_d = ST_I_WB;
        ST_BRANCH:   state_d = zero ? ST_FETCH : ST_BR_NT;
`ifdef ILLEGAL_SKIP_EN
        ST_ILLEGAL:  state_d = ST_FETCH;
`else
        ST_ILLEGAL:  state_d = ST_ILLEGAL;
`endif
        default:     state_d = ST_FETCH;
      endcase
    end
  end

  // Moore outputs only; zero enters solely through the BRANCH terms below,
  // which keeps the ALU select path free of any dependence on the ALU result.
  always_comb begin
    pcw_m      = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSource   = 1'b0;
    ALUControl = ALU_ADD;
    done_m     = 1'b0;
    illegal    = 1'b0;
    br_s       = 1'b0;
    pc_inc     = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH:              begin MemRead = 1'b1; IRWrite = 1'b1; end
        ST_DECODE:             ALUSrcB = SRCB_IMM;
        ST_MEM_ADDR, ST_EXEC_I: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
        ST_MEM_RD:             begin IorD = 1'b1; MemRead = 1'b1; pc_inc = 1'b1; end
        ST_MEM_WB:             begin RegWrite = 1'b1; MemtoReg = 1'b1; done_m = 1'b1; end
        ST_MEM_WR:             begin IorD = 1'b1; MemWrite = 1'b1; pc_inc = 1'b1; done_m = 1'b1; end
        ST_EXEC_R:             begin ALUSrcA = 1'b1; ALUControl = r_alu_ctrl; end
        ST_R_WB, ST_I_WB:      begin RegWrite = 1'b1; pc_inc = 1'b1; done_m = 1'b1; end
        ST_BRANCH:             begin ALUSrcA = 1'b1; ALUControl = ALU_SUB; PCSource = 1'b1; br_s = 1'b1; end
        ST_BR_NT:              begin pc_inc = 1'b1; done_m = 1'b1; end
        ST_ILLEGAL: begin
          illegal = 1'b1;
`ifdef ILLEGAL_SKIP_EN
          pc_inc  = 1'b1;
          done_m  = 1'b1;
`endif
        end
        default: ;
      endcase
      if (pc_inc) begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        PCSource   = 1'b0;
        pcw_m      = 1'b1;
      end
    end
  end

  assign PCWrite    = pcw_m  | (br_s & zero);
  assign instr_done = done_m | (br_s & zero);

endmodule
